// File: rtl/hash_result_pkg.sv
// Shared types and helpers for the hash result writer: FSM states, record
// layout and digest word selection.
package hash_result_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CMP   = 2'd1,
    ST_WRITE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // A record is the eight digest words followed by the nonce.
  localparam int WORDS_PER_RECORD = 9;
  localparam int NONCE_WORD_IDX   = 8;
  localparam int WORD_IDX_W       = 4;

  // Word 0 is the most significant 32 bits of the digest.
  function automatic logic [31:0] digest_word(input logic [255:0] digest, input int k);
    return digest[255 - 32*k -: 32];
  endfunction

endpackage

// File: rtl/hash_ring_ctrl.sv
// Ring-buffer bookkeeping: write/read slot pointers, occupancy and the
// arbitration between a record being committed and the host popping one.
module hash_ring_ctrl
  import hash_result_pkg::*;
#(
  parameter int NUM_SLOTS = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  output logic [$clog2(NUM_SLOTS)-1:0] wr_ptr,
  output logic [$clog2(NUM_SLOTS):0]   entry_count,
  output logic                         buffer_full
);

  localparam int PTR_W   = $clog2(NUM_SLOTS);
  localparam int COUNT_W = PTR_W + 1;

  logic [PTR_W-1:0]   wr_ptr_reg;
  logic [PTR_W-1:0]   rd_ptr_reg;
  logic [COUNT_W-1:0] entry_count_reg;
  logic               pop_eff;

  // A pop on an empty ring is ignored. The writer never pushes while full
  // because the compare stage drops the record in that case.
  assign pop_eff = pop && (entry_count_reg != '0);

  // Pointers wrap naturally since NUM_SLOTS is a power of two; a coincident
  // push and pop leave the occupancy unchanged while both pointers move.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg      <= '0;
      rd_ptr_reg      <= '0;
      entry_count_reg <= '0;
    end else begin
      if (push)
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop_eff)
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      case ({push, pop_eff})
        2'b10:   entry_count_reg <= entry_count_reg + COUNT_W'(1);
        2'b01:   entry_count_reg <= entry_count_reg - COUNT_W'(1);
        default: entry_count_reg <= entry_count_reg;
      endcase
    end
  end

  assign wr_ptr      = wr_ptr_reg;
  assign entry_count = entry_count_reg;
  assign buffer_full = (entry_count_reg == COUNT_W'(NUM_SLOTS));

endmodule

// File: rtl/hash_result_writer.sv
// Takes finished SHA-256 digests with their nonces, compares each against
// the target and serializes qualifying results into the result RAM ring.
module hash_result_writer
  import hash_result_pkg::*;
#(
  parameter int NUM_SLOTS   = 32,
  parameter int SLOT_STRIDE = 16,
  parameter int ADDR_W      = 9,
  parameter int CNT_W       = 16
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       hash_valid,
  output logic                       hash_ready,
  input  logic [255:0]               hash_digest,
  input  logic [31:0]                nonce,
  input  logic [255:0]               target,
  input  logic                       store_all,
  input  logic                       pop,
  output logic [31:0]                data_out,
  output logic [ADDR_W-1:0]          writeaddress,
  output logic                       mem_write,
  output logic                       record_done,
  output logic                       hit,
  output logic [$clog2(NUM_SLOTS):0] entry_count,
  output logic                       buffer_full,
  output logic [CNT_W-1:0]           hit_count,
  output logic [CNT_W-1:0]           drop_count
);

  localparam int PTR_W = $clog2(NUM_SLOTS);

  state_t                state_reg, state_next;
  logic [WORD_IDX_W-1:0] k_reg, k_next;
  logic                  ready_en_reg;
  logic [255:0]          digest_reg;
  logic [31:0]           nonce_reg;
  logic                  hit_reg;
  logic [CNT_W-1:0]      hit_count_reg;
  logic [CNT_W-1:0]      drop_count_reg;

  logic                  load;
  logic                  push;
  logic                  is_hit;
  logic                  store;
  logic                  drop_inc;
  logic [PTR_W-1:0]      wr_ptr;
  logic [31:0]           rec_words [WORDS_PER_RECORD];

  hash_ring_ctrl #(
    .NUM_SLOTS (NUM_SLOTS)
  ) u_ring (
    .clk         (clk),
    .reset       (reset),
    .push        (push),
    .pop         (pop),
    .wr_ptr      (wr_ptr),
    .entry_count (entry_count),
    .buffer_full (buffer_full)
  );

  // Record image: digest words 0..7 then the nonce.
  for (genvar gi = 0; gi < NONCE_WORD_IDX; gi++) begin : g_rec_word
    assign rec_words[gi] = digest_word(digest_reg, gi);
  end
  assign rec_words[NONCE_WORD_IDX] = nonce_reg;

  // target and store_all only matter while the FSM sits in CMP.
  assign is_hit = (digest_reg < target);
  assign store  = is_hit | store_all;

  // State, word index and the ready enable that holds hash_ready low until
  // the first clock after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= ST_IDLE;
      k_reg        <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      ready_en_reg <= 1'b1;
    end
  end

  // Capture the accepted digest/nonce and the compare result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      digest_reg <= '0;
      nonce_reg  <= '0;
      hit_reg    <= 1'b0;
    end else begin
      if (load) begin
        digest_reg <= hash_digest;
        nonce_reg  <= nonce;
      end
      if (state_reg == ST_CMP)
        hit_reg <= is_hit;
    end
  end

  // Saturating hit and drop statistics.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hit_count_reg  <= '0;
      drop_count_reg <= '0;
    end else begin
      if (state_reg == ST_CMP && is_hit && hit_count_reg != {CNT_W{1'b1}})
        hit_count_reg <= hit_count_reg + CNT_W'(1);
      if (drop_inc && drop_count_reg != {CNT_W{1'b1}})
        drop_count_reg <= drop_count_reg + CNT_W'(1);
    end
  end

  // Next-state logic and the RAM write port. Outputs are decoded from the
  // state register so an asynchronous reset silences the port immediately.
  always_comb begin
    state_next   = state_reg;
    k_next       = k_reg;
    load         = 1'b0;
    push         = 1'b0;
    drop_inc     = 1'b0;
    hash_ready   = 1'b0;
    mem_write    = 1'b0;
    record_done  = 1'b0;
    data_out     = '0;
    writeaddress = '0;
    case (state_reg)
      ST_IDLE: begin
        hash_ready = ready_en_reg;
        if (hash_valid && ready_en_reg) begin
          load       = 1'b1;
          state_next = ST_CMP;
        end
      end
      ST_CMP: begin
        if (store && !buffer_full) begin
          state_next = ST_WRITE;
        end else begin
          drop_inc   = store;
          state_next = ST_IDLE;
        end
      end
      ST_WRITE: begin
        mem_write    = 1'b1;
        writeaddress = ADDR_W'(wr_ptr) * ADDR_W'(SLOT_STRIDE) + ADDR_W'(k_reg);
        data_out     = rec_words[k_reg];
        if (k_reg == WORD_IDX_W'(NONCE_WORD_IDX)) begin
          k_next     = '0;
          state_next = ST_DONE;
        end else begin
          k_next = k_reg + WORD_IDX_W'(1);
        end
      end
      ST_DONE: begin
        record_done = 1'b1;
        push        = 1'b1;
        state_next  = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign hit        = hit_reg;
  assign hit_count  = hit_count_reg;
  assign drop_count = drop_count_reg;

endmodule

// File: doc/hash_result_writer.md
Name: hash_result_writer

Overview:
- Downstream stage of acc_top's SHA-256 core.
- Accepts each finished 256-bit digest together with the nonce that produced it, and compares the digest against a 256-bit target.
- Qualifying results are serialized as 32-bit words into the result RAM ring buffer, which the host drains.
- Drives the same data_out / writeaddress style write port used by acc_top.

Parameters:
- NUM_SLOTS, 32, ring-buffer record slots; power of two.
- SLOT_STRIDE, 16, words reserved per slot; power of two, ≥9.
- ADDR_W, 9, write-address width; must satisfy NUM_SLOTS*SLOT_STRIDE ≤ 2^ADDR_W.
- CNT_W, 16, width of the hit and drop counters.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- hash_valid  in  1  digest/nonce valid from SHA core.
- hash_ready  out  1  block can accept a digest.
- hash_digest  in  256  digest; bits 255:224 are word 0, most significant.
- nonce  in  32  nonce associated with the digest.
- target  in  256  difficulty target, quasi-static host register.
- store_all  in  1  1 = store every digest; 0 = store hits only.
- pop  in  1  host has consumed the oldest record (1-cycle pulse).
- data_out  out  32  RAM write data.
- writeaddress  out  ADDR_W  RAM write address.
- mem_write  out  1  RAM write strobe.
- record_done  out  1  1-cycle pulse after a record is fully written.
- hit  out  1  registered result of the last compare.
- entry_count  out  $clog2(NUM_SLOTS)+1  records held in the ring.
- buffer_full  out  1  entry_count == NUM_SLOTS.
- hit_count  out  CNT_W  saturating count of hits.
- drop_count  out  CNT_W  saturating count of records lost because the buffer was full.

Behaviour:
- Reset values (reset=0): all outputs 0, except hash_ready = 0 while in reset.
  - Internal state: FSM=IDLE, wr_ptr=0, rd_ptr=0, word index k=0.
  - hash_ready rises in the first cycle after reset deasserts.
- FSM states: IDLE, CMP, WRITE, DONE.
- IDLE:
  - hash_ready=1.
  - When hash_valid && hash_ready (cycle T): latch digest and nonce, go to CMP.
- CMP (T+1):
  - hash_ready=0.
  - hit <= (digest < target), unsigned 256-bit compare.
  - If hit, hit_count++ (saturating).
  - store = hit | store_all.
  - store && !buffer_full → WRITE.
  - store && buffer_full → drop_count++ (saturating), go to IDLE.
  - !store → IDLE.
- WRITE (T+2..T+10): 9 cycles, k = 0..8.
  - mem_write=1.
  - writeaddress = wr_ptr*SLOT_STRIDE + k.
  - data_out = digest word k for k ≤ 7; nonce for k = 8.
  - No other word addresses are written.
- DONE (T+11):
  - record_done=1.
  - wr_ptr <= wr_ptr+1, wrapping NUM_SLOTS-1 → 0.
  - entry_count++ .
  - Next state IDLE; hash_ready=1 at T+12.
- Minimum accept-to-accept interval:
  - 12 cycles for a stored record.
  - 2 cycles for a discarded digest.
- pop:
  - Effective when entry_count > 0: rd_ptr++ (wrapping) and entry_count-- .
  - pop when entry_count == 0 is ignored.
  - pop coincident with the DONE increment: entry_count is unchanged; both pointers advance.
- buffer_full:
  - Combinational from entry_count.
  - A pop in the same cycle as CMP does not unblock that compare; the compare uses the registered count.
- target and store_all are sampled in CMP only; changes at other times do not affect a record in flight.
- Reset mid-WRITE: mem_write drops immediately and the partial record is abandoned. The pointer is not advanced because all pointers reset.
- Counters saturate at 2^CNT_W-1 and never wrap.

Decomposition:
- Package hash_result_pkg holds:
  - the state enum for IDLE, CMP, WRITE, DONE;
  - WORDS_PER_RECORD = 9;
  - NONCE_WORD_IDX = 8;
  - the digest word-select function (word k = digest[255-32k -: 32]).
- Sub-module hash_ring_ctrl holds wr_ptr, rd_ptr, entry_count, buffer_full and the pop/push arbitration. The top level holds the FSM, compare and serializer.

Test Plan:
- Hit and write:
  - Stimulus: digest 2a19f8a396959e87a0607a7eae4abb941135e49b8d342e7bb923a7ca33b09ff7, nonce 0x12345678, target 0x2a1a0000…0, store_all=0.
  - Response: hit=1 at T+2.
  - Writes at addresses 0..8 on T+2..T+10 with data 2a19f8a3, 96959e87, …, 33b09ff7, 12345678.
  - record_done at T+11; entry_count=1; hit_count=1.
- Miss discarded:
  - Stimulus: same digest, target 0x2a19f8a3000…0, store_all=0.
  - Response: hit=0, no mem_write, hash_ready high again at T+2, entry_count unchanged.
- store_all:
  - Stimulus: same miss with store_all=1.
  - Response: record written to slot 0; hit_count stays 0.
- Full and wrap:
  - Stimulus: 32 hits with no pop, then a 33rd hit.
  - Response: buffer_full=1; 33rd hit gives drop_count=1 and no mem_write.
  - Then pop once and send another hit: written at addresses 0..8 (wr_ptr wrapped), entry_count=32.
- Simultaneous pop and DONE:
  - Stimulus: entry_count=3, pop asserted in the DONE cycle.
  - Response: entry_count stays 3; rd_ptr and wr_ptr both advance.
- Reset mid-record:
  - Stimulus: assert reset at k=4 of a WRITE.
  - Response: all outputs are 0 the same cycle.
  - After release, the next hit writes at address 0 and entry_count=1.
